// File: rtl/q_update.sv
// Q-learning update Q_new = Q_old + Alpha*(Reward + gamma_maxQ - Q_old); three register stages, 3-cycle latency.
// A held output (out_valid && !out_ready) freezes every stage and deasserts in_ready combinationally.
module q_update #(
    parameter int W    = 24,
    parameter int FRAC = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Q_old,
    input  logic [W-1:0] Reward,
    input  logic [W-1:0] gamma_maxQ,
    input  logic [W-1:0] Alpha,
    input  logic [2:0]   S_in,
    input  logic [1:0]   A_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Q_new,
    output logic [2:0]   S_out,
    output logic [1:0]   A_out,
    output logic [15:0]  upd_cnt
);

    localparam logic signed [2*W-1:0] SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    // All intermediate arithmetic is done at 2W bits, wide enough that no stage can wrap.
    function automatic logic signed [2*W-1:0] sext(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [2*W-1:0] x);
        logic [W-1:0] r;
        if (x > SMAX)      r = {1'b0, {(W-1){1'b1}}};
        else if (x < SMIN) r = {1'b1, {(W-1){1'b0}}};
        else               r = x[W-1:0];
        return r;
    endfunction

    logic         en;
    logic         s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, out_vld_q, out_vld_d;
    logic [W-1:0] s1_t_q, s1_t_d, s1_alpha_q, s1_alpha_d, s1_qold_q, s1_qold_d;
    logic [W-1:0] s2_p_q, s2_p_d, s2_qold_q, s2_qold_d, q_new_q, q_new_d;
    logic [2:0]   s1_s_q, s1_s_d, s2_s_q, s2_s_d, s_out_q, s_out_d;
    logic [1:0]   s1_a_q, s1_a_d, s2_a_q, s2_a_d, a_out_q, a_out_d;
    logic [15:0]  cnt_q, cnt_d;
    logic signed [2*W-1:0] t_wide, prod, prod_sh, q_sum;

    always_comb begin
        en       = !(out_vld_q && !out_ready);
        t_wide   = sext(Reward) + sext(gamma_maxQ) - sext(Q_old);
        prod     = sext(s1_alpha_q) * sext(s1_t_q);
        prod_sh  = prod >>> FRAC;
        q_sum    = sext(s2_qold_q) + sext(s2_p_q);

        s1_vld_d   = s1_vld_q;
        s1_t_d     = s1_t_q;
        s1_alpha_d = s1_alpha_q;
        s1_qold_d  = s1_qold_q;
        s1_s_d     = s1_s_q;
        s1_a_d     = s1_a_q;
        s2_vld_d   = s2_vld_q;
        s2_p_d     = s2_p_q;
        s2_qold_d  = s2_qold_q;
        s2_s_d     = s2_s_q;
        s2_a_d     = s2_a_q;
        out_vld_d  = out_vld_q;
        q_new_d    = q_new_q;
        s_out_d    = s_out_q;
        a_out_d    = a_out_q;
        cnt_d      = cnt_q;

        if (en) begin
            s1_vld_d   = in_valid;
            s1_t_d     = sat(t_wide);
            s1_alpha_d = Alpha;
            s1_qold_d  = Q_old;
            s1_s_d     = S_in;
            s1_a_d     = A_in;
            s2_vld_d   = s1_vld_q;
            s2_p_d     = sat(prod_sh);
            s2_qold_d  = s1_qold_q;
            s2_s_d     = s1_s_q;
            s2_a_d     = s1_a_q;
            out_vld_d  = s2_vld_q;
            q_new_d    = sat(q_sum);
            s_out_d    = s2_s_q;
            a_out_d    = s2_a_q;
        end

        if (out_vld_q && out_ready && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_t_q     <= '0;
            s1_alpha_q <= '0;
            s1_qold_q  <= '0;
            s1_s_q     <= '0;
            s1_a_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_p_q     <= '0;
            s2_qold_q  <= '0;
            s2_s_q     <= '0;
            s2_a_q     <= '0;
            out_vld_q  <= 1'b0;
            q_new_q    <= '0;
            s_out_q    <= '0;
            a_out_q    <= '0;
            cnt_q      <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_t_q     <= s1_t_d;
            s1_alpha_q <= s1_alpha_d;
            s1_qold_q  <= s1_qold_d;
            s1_s_q     <= s1_s_d;
            s1_a_q     <= s1_a_d;
            s2_vld_q   <= s2_vld_d;
            s2_p_q     <= s2_p_d;
            s2_qold_q  <= s2_qold_d;
            s2_s_q     <= s2_s_d;
            s2_a_q     <= s2_a_d;
            out_vld_q  <= out_vld_d;
            q_new_q    <= q_new_d;
            s_out_q    <= s_out_d;
            a_out_q    <= a_out_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign Q_new     = q_new_q;
    assign S_out     = s_out_q;
    assign A_out     = a_out_q;
    assign upd_cnt   = cnt_q;

endmodule

// File: tb/tb_q_update.sv
// Bench for q_update: fixed vectors, backpressure/reset sequences, and randomized traffic against a scoreboard.
module tb_q_update;

    localparam int W    = 24;
    localparam int FRAC = 14;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] Q_old, Reward, gamma_maxQ, Alpha, Q_new;
    logic [2:0]   S_in, S_out;
    logic [1:0]   A_in, A_out;
    logic [15:0]  upd_cnt;

    q_update #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Q_old(Q_old), .Reward(Reward), .gamma_maxQ(gamma_maxQ), .Alpha(Alpha),
        .S_in(S_in), .A_in(A_in), .out_valid(out_valid), .out_ready(out_ready),
        .Q_new(Q_new), .S_out(S_out), .A_out(A_out), .upd_cnt(upd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [2:0]   s;
        logic [1:0]   a;
    } exp_t;

    typedef struct {
        logic [W-1:0] q, r, g, al;
        logic [2:0]   s;
        logic [1:0]   a;
        logic [W-1:0] exp_q;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[9];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_acc = 0;
    bit          last_acc = 1'b0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint clampw(input longint x);
        longint hi, lo;
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -(longint'(1) <<< (W-1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Reference: exact integer arithmetic, floor division, clamp each intermediate.
    function automatic logic [W-1:0] ref_q(input logic [W-1:0] q, r, g, al);
        longint t, prod, div, p, n;
        div  = longint'(1) <<< FRAC;
        t    = clampw(sx(r) + sx(g) - sx(q));
        prod = sx(al) * t;
        p    = prod / div;
        if (prod < 0 && (prod % div) != 0) p = p - 1;
        p    = clampw(p);
        n    = clampw(sx(q) + p);
        return n[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r = r;
            1: r = 32'($signed(32'($urandom_range(0, 32'h20000))) - 32'sh10000);
            2: r = r[0] ? 32'h007FFFFF : 32'h00800000;
            default: r = 32'h4000 + 32'($urandom_range(0, 255));
        endcase
        return r[W-1:0];
    endfunction

    task automatic drive_rand();
        logic [31:0] r;
        in_valid   = 1'b1;
        Q_old      = rand_op();
        Reward     = rand_op();
        gamma_maxQ = rand_op();
        r          = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 32'h4000));
        Alpha      = r[W-1:0];
        r          = 32'($urandom_range(0, 5));
        S_in       = r[2:0];
        r          = $urandom;
        A_in       = r[1:0];
    endtask

    // One clock: sample handshakes at the falling edge, update the model, return 1 unit after the rising edge.
    task automatic step();
        exp_t e;
        bit   acc, fire;
        @(negedge clk);
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            chk("upd_cnt", 32'(upd_cnt), 32'(exp_cnt));
            if (fire) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL stale_output: got Q_new=%h with nothing expected", Q_new);
                end else begin
                    e = sb.pop_front();
                    chk("Q_new", 32'(Q_new), 32'(e.q));
                    chk("S_out", 32'(S_out), 32'(e.s));
                    chk("A_out", 32'(A_out), 32'(e.a));
                end
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            if (acc) begin
                e.q = ref_q(Q_old, Reward, gamma_maxQ, Alpha);
                e.s = S_in;
                e.a = A_in;
                sb.push_back(e);
                n_acc++;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            exp_cnt = '0;
        end
        last_acc = acc && rst_n;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held_q;
        logic [2:0]   held_s;
        int           base;

        vt[0] = '{24'h000000, 24'h004000, 24'h002000, 24'h002000, 3'd0, 2'd0, 24'h003000};
        vt[1] = '{24'h004000, 24'h000000, 24'h000000, 24'h002000, 3'd1, 2'd1, 24'h002000};
        vt[2] = '{24'h000000, 24'h7FFFFF, 24'h7FFFFF, 24'h004000, 3'd2, 2'd2, 24'h7FFFFF};
        vt[3] = '{24'h000000, 24'h800000, 24'h800000, 24'h004000, 3'd3, 2'd3, 24'h800000};
        vt[4] = '{24'h000000, 24'h000001, 24'h000000, 24'h002000, 3'd4, 2'd0, 24'h000000};
        vt[5] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h002000, 3'd0, 2'd1, 24'hFFFFFF};
        vt[6] = '{24'h700000, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 3'd1, 2'd2, 24'h7FFFFF};
        vt[7] = '{24'h900000, 24'h800000, 24'h800000, 24'h7FFFFF, 3'd2, 2'd0, 24'h800000};
        vt[8] = '{24'h000000, 24'h004000, 24'h002000, 24'h002000, 3'd5, 2'd3, 24'h003000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Q_old = '0; Reward = '0; gamma_maxQ = '0; Alpha = '0; S_in = '0; A_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_Q_new", 32'(Q_new), 32'd0);
        chk("rst_S_out", 32'(S_out), 32'd0);
        chk("rst_A_out", 32'(A_out), 32'd0);
        chk("rst_upd_cnt", 32'(upd_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            Q_old = vt[i].q; Reward = vt[i].r; gamma_maxQ = vt[i].g; Alpha = vt[i].al;
            S_in = vt[i].s; A_in = vt[i].a; in_valid = 1'b1;
            step();
            chk("vec_accept", 32'(last_acc), 32'd1);
            in_valid = 1'b0;
            step();
            chk("vec_early", 32'(out_valid), 32'd0);
            step();
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_Q_new", 32'(Q_new), 32'(vt[i].exp_q));
            chk("vec_S_out", 32'(S_out), 32'(vt[i].s));
            chk("vec_A_out", 32'(A_out), 32'(vt[i].a));
            step();
        end

        rst_n = 1'b0; step(); rst_n = 1'b1;
        out_ready = 1'b0; in_valid = 1'b0; base = n_acc;
        for (int k = 0; k < 6; k++) begin
            if (last_acc || !in_valid) begin
                if (n_acc - base < 4) drive_rand(); else in_valid = 1'b0;
            end
            step();
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepted", 32'(n_acc - base), 32'd3);
        held_q = Q_new; held_s = S_out;
        step(); step();
        chk("bp_hold_Q", 32'(Q_new), 32'(held_q));
        chk("bp_hold_S", 32'(S_out), 32'(held_s));
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (sb.size() > 0 || n_acc - base < 4); k++) begin
            if (last_acc || !in_valid) begin
                if (n_acc - base < 4) drive_rand(); else in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        chk("bp_upd_cnt", 32'(upd_cnt), 32'd4);
        chk("bp_all_out", 32'(sb.size()), 32'd0);

        drive_rand(); step();
        drive_rand(); step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_upd_cnt", 32'(upd_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        end

        for (int k = 0; k < 400; k++) begin
            if (last_acc || !in_valid) begin
                if ($urandom_range(0, 9) < 7) drive_rand(); else in_valid = 1'b0;
            end
            out_ready = $urandom_range(0, 9) < 7;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        chk("rand_drained", 32'(sb.size()), 32'd0);

        Q_old = '0; Reward = '0; gamma_maxQ = '0; Alpha = '0; S_in = 3'd5; A_in = 2'd3;
        in_valid = 1'b1;
        for (int k = 0; k < 70000 && upd_cnt != 16'hFFFF; k++) step();
        chk("cnt_reach_max", 32'(upd_cnt), 32'h0000FFFF);
        repeat (5) step();
        chk("cnt_hold_max", 32'(upd_cnt), 32'h0000FFFF);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
